write_state: RTL and testbench
==============================

Name: write_state

Overview:
Write-domain pointer manager for the dual-clock gray-pointer FIFO. It pairs with the read-side pointer block.
- Owns the binary write address and drives the memory write enable.
- Publishes a registered gray write pointer for the read domain.
- Synchronizes the incoming gray read pointer and derives full, almost_full, fill level and a sticky overflow flag.

Parameters:
ADDRESS_WIDTH, 4, pointer/address width; FIFO capacity is 2^ADDRESS_WIDTH - 1 entries (one slot sacrificed).
SYNC_STAGES, 2, flop stages on the incoming read gray pointer; legal values are 2 or more.
ALMOST_FULL_THRESHOLD, 12, level at or above which almost_full asserts; legal range is 1 to 2^ADDRESS_WIDTH - 1.

Ports:
clock  input  1  write-domain clock; all logic is on its rising edge
reset  input  1  synchronous, active-high reset
increment  input  1  write request for this cycle
clear_overflow  input  1  clears the sticky overflow flag
read_address_gray  input  ADDRESS_WIDTH  gray read pointer from the read domain (asynchronous to clock)
write_address  output  ADDRESS_WIDTH  binary write address to the memory write port
write_address_gray  output  ADDRESS_WIDTH  registered gray write pointer sent to the read domain
write_enable  output  1  memory write strobe
full  output  1  FIFO holds 2^ADDRESS_WIDTH - 1 entries
almost_full  output  1  level >= ALMOST_FULL_THRESHOLD
level  output  ADDRESS_WIDTH  write-side view of occupancy
overflow  output  1  sticky flag: a write was attempted while full

Behaviour:
- Interface is fixed: one clock, named clock; reset is synchronous and active-high, named reset.
- Reset (reset high at a clock edge):
  - write_address, write_address_gray, all sync flops and overflow go to 0.
  - After reset: full=0, almost_full=0, level=0.
  - Reset applies mid-operation with no drain; the read domain must be reset in the same system reset event.
- Synchronizer:
  - read_address_gray passes through SYNC_STAGES flops.
  - The last stage is decoded with gray_to_binary to give read_address_sync.
  - No logic is permitted between sync stages.
- Write acceptance:
  - write_enable = increment & !full, combinational from registers plus increment.
  - Memory writes at the current write_address.
- Pointer update:
  - When write_enable is high, write_address advances by 1 modulo 2^ADDRESS_WIDTH (15 -> 0 at width 4).
  - In the same edge, write_address_gray loads binary_to_gray(write_address + 1).
  - write_address_gray is therefore always a flop output, glitch-free, and changes exactly one bit per write.
- full = ((write_address + 1) mod 2^ADDRESS_WIDTH) == read_address_sync.
- level = (write_address - read_address_sync) mod 2^ADDRESS_WIDTH.
- almost_full = (level >= ALMOST_FULL_THRESHOLD).
- Latency:
  - A write is visible on write_address_gray 1 cycle after the accepting edge.
  - A read-pointer change is reflected in full/level SYNC_STAGES clock edges after it is stable at the input.
  - full/level are therefore pessimistic: they may report more occupancy than is real, never less.
- Overflow:
  - Set on any cycle with increment & full; the write is dropped and all pointers hold.
  - Cleared by clear_overflow.
  - If set and clear occur in the same cycle, set wins.
- Width rules: all pointer arithmetic is ADDRESS_WIDTH bits with natural wrap; no extra wrap bit.
- Compatibility with the read side: the read side reports empty when its pointer equals the write pointer.

Decomposition:
- Package fifo_pkg holds:
  - DEFAULT_ADDRESS_WIDTH = 4 and DEFAULT_SYNC_STAGES = 2.
  - Function capacity(width) = 2^width - 1.
- Reuse the existing binary_to_gray and gray_to_binary, instantiated with WIDTH = ADDRESS_WIDTH (never a literal).
- One new sub-module: gray_sync, a parameterized WIDTH × STAGES flop chain with synchronous reset. It is shared later by the read side.

Test Plan:
- Reset: hold reset 2 cycles with increment=1 -> all outputs 0, write_enable=1 only after reset deasserts, overflow=0.
- Fill (read_address_gray=0): increment for 15 cycles.
  - Result: write_address=15, write_address_gray=4'b1000, level=15, full=1.
  - 16th increment: write_enable=0, address holds at 15, overflow=1 next cycle.
- Release: from full, drive read_address_gray=4'b0001 (binary 1) -> full stays 1 for exactly 2 edges then drops, level=14; one write is then accepted and full re-asserts.
- Wrap: read pointer gray of 14 (4'b1001), write_address=15; one write gives write_address=0, write_address_gray=4'b0000, level=2.
- Almost-full: read=0, level 11 -> 12 on the 12th write -> almost_full rises the same edge as level.
- Overflow priority: overflow=1, full=1, increment=1 with clear_overflow=1 -> overflow stays 1; the next cycle with increment=0 and clear_overflow=1 -> overflow=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and helpers for the dual-clock gray-pointer FIFO
// Contents: DEFAULT_ADDRESS_WIDTH, DEFAULT_SYNC_STAGES, capacity(width) = usable entries
package fifo_pkg;
   localparam int DEFAULT_ADDRESS_WIDTH = 4;
   localparam int DEFAULT_SYNC_STAGES = 2;
   function automatic int capacity(input int width);
      return (1 << width) - 1;
   endfunction
endpackage

// File: rtl/binary_to_gray.sv
// binary_to_gray: combinational binary to reflected gray code converter
// Ports: binary (in, WIDTH), gray (out, WIDTH)
module binary_to_gray #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] binary,
   output logic [WIDTH-1:0] gray
);
   assign gray = binary ^ (binary >> 1);
endmodule

// File: rtl/gray_sync.sv
// gray_sync: WIDTH x STAGES flop chain carrying a gray pointer across clock domains
// Ports: clock, reset (sync, active-high), async_data (in, WIDTH), sync_data (out, WIDTH)
module gray_sync #(
   parameter int WIDTH = 4,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_data,
   output logic [WIDTH-1:0] sync_data
);
   if (STAGES < 2) begin : g_bad_stages
      $error("gray_sync needs at least two stages");
   end
   logic [WIDTH-1:0] stage [STAGES];
   // Pure flop-to-flop chain: nothing may sit between stages.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) stage[i] <= '0;
      end else begin
         stage[0] <= async_data;
         for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
   end
   assign sync_data = stage[STAGES-1];
endmodule

// File: rtl/gray_to_binary.sv
// gray_to_binary: combinational reflected gray code to binary converter
// Ports: gray (in, WIDTH), binary (out, WIDTH)
module gray_to_binary #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] binary
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign binary[i] = ^gray[WIDTH-1:i];
   end
endmodule

// File: rtl/write_state.sv
// write_state: write-domain pointer manager for the dual-clock gray-pointer FIFO
// Ports: clock, reset (sync, active-high), increment, clear_overflow, read_address_gray (async in);
//        write_address, write_address_gray (registered), write_enable, full, almost_full, level, overflow
module write_state
   import fifo_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter int ALMOST_FULL_THRESHOLD = 12
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     increment,
   input  logic                     clear_overflow,
   input  logic [ADDRESS_WIDTH-1:0] read_address_gray,
   output logic [ADDRESS_WIDTH-1:0] write_address,
   output logic [ADDRESS_WIDTH-1:0] write_address_gray,
   output logic                     write_enable,
   output logic                     full,
   output logic                     almost_full,
   output logic [ADDRESS_WIDTH-1:0] level,
   output logic                     overflow
);
   if (ALMOST_FULL_THRESHOLD < 1 || ALMOST_FULL_THRESHOLD > capacity(ADDRESS_WIDTH)) begin : g_bad_threshold
      $error("ALMOST_FULL_THRESHOLD out of range");
   end
   localparam logic [ADDRESS_WIDTH-1:0] ALMOST_FULL_LEVEL = ADDRESS_WIDTH'(ALMOST_FULL_THRESHOLD);
   logic [ADDRESS_WIDTH-1:0] next_address;
   logic [ADDRESS_WIDTH-1:0] next_address_gray;
   logic [ADDRESS_WIDTH-1:0] read_gray_sync;
   logic [ADDRESS_WIDTH-1:0] read_address_sync;
   gray_sync #(.WIDTH(ADDRESS_WIDTH), .STAGES(SYNC_STAGES)) read_sync (
      .clock(clock),
      .reset(reset),
      .async_data(read_address_gray),
      .sync_data(read_gray_sync)
   );
   gray_to_binary #(.WIDTH(ADDRESS_WIDTH)) read_decode (
      .gray(read_gray_sync),
      .binary(read_address_sync)
   );
   binary_to_gray #(.WIDTH(ADDRESS_WIDTH)) write_encode (
      .binary(next_address),
      .gray(next_address_gray)
   );
   assign next_address = write_address + 1'b1;
   assign full = next_address == read_address_sync;
   assign level = write_address - read_address_sync;
   assign almost_full = level >= ALMOST_FULL_LEVEL;
   // Held low during reset so no stray memory write lands while pointers clear.
   assign write_enable = increment & ~full & ~reset;
   // The gray pointer is loaded from the encoded next address so the read domain
   // only ever sees a flop output changing one bit per write.
   always_ff @(posedge clock) begin
      if (reset) begin
         write_address <= '0;
         write_address_gray <= '0;
         overflow <= 1'b0;
      end else begin
         if (write_enable) begin
            write_address <= next_address;
            write_address_gray <= next_address_gray;
         end
         if (increment && full) overflow <= 1'b1;
         else if (clear_overflow) overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_write_state.sv
// tb_write_state: directed self-checking bench for write_state
module tb_write_state;
   localparam int AW = 4;
   localparam logic [AW-1:0] GRAY [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                            4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic increment = 1'b0;
   logic clear_overflow = 1'b0;
   logic [AW-1:0] read_address_gray = '0;
   logic [AW-1:0] write_address, write_address_gray, level;
   logic write_enable, full, almost_full, overflow;
   int check_count = 0;
   int pass_count = 0;

   always #5 clock = ~clock;

   write_state #(.ADDRESS_WIDTH(AW), .SYNC_STAGES(2), .ALMOST_FULL_THRESHOLD(12)) dut (
      .clock(clock),
      .reset(reset),
      .increment(increment),
      .clear_overflow(clear_overflow),
      .read_address_gray(read_address_gray),
      .write_address(write_address),
      .write_address_gray(write_address_gray),
      .write_enable(write_enable),
      .full(full),
      .almost_full(almost_full),
      .level(level),
      .overflow(overflow)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      increment = 1'b0;
      clear_overflow = 1'b0;
      read_address_gray = '0;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      increment = 1'b1;
      step();
      check_count++; if (write_enable !== 1'b0) $display("FAIL reset_we_1: got %b want 0", write_enable); else pass_count++;
      step();
      check_count++; if (write_enable !== 1'b0) $display("FAIL reset_we_2: got %b want 0", write_enable); else pass_count++;
      check_count++; if (write_address !== 4'd0) $display("FAIL reset_wa: got %0d want 0", write_address); else pass_count++;
      check_count++; if (write_address_gray !== 4'd0) $display("FAIL reset_gray: got %b want 0000", write_address_gray); else pass_count++;
      check_count++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else pass_count++;
      check_count++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else pass_count++;
      check_count++; if (almost_full !== 1'b0) $display("FAIL reset_af: got %b want 0", almost_full); else pass_count++;
      check_count++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else pass_count++;
      reset = 1'b0;
      #1;
      check_count++; if (write_enable !== 1'b1) $display("FAIL reset_we_release: got %b want 1", write_enable); else pass_count++;
      increment = 1'b0;
   endtask

   task automatic test_fill();
      do_reset();
      increment = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         step();
         check_count++; if (write_address !== 4'(i)) $display("FAIL fill_wa[%0d]: got %0d want %0d", i, write_address, i); else pass_count++;
         check_count++; if (write_address_gray !== GRAY[i]) $display("FAIL fill_gray[%0d]: got %b want %b", i, write_address_gray, GRAY[i]); else pass_count++;
         check_count++; if (level !== 4'(i)) $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i); else pass_count++;
         check_count++; if (full !== (i == 15)) $display("FAIL fill_full[%0d]: got %b want %b", i, full, i == 15); else pass_count++;
      end
      check_count++; if (write_address_gray !== 4'b1000) $display("FAIL fill_gray_15: got %b want 1000", write_address_gray); else pass_count++;
      check_count++; if (write_enable !== 1'b0) $display("FAIL fill_we_full: got %b want 0", write_enable); else pass_count++;
      check_count++; if (overflow !== 1'b0) $display("FAIL fill_ovf_pre: got %b want 0", overflow); else pass_count++;
      step();
      check_count++; if (write_address !== 4'd15) $display("FAIL fill_wa_hold: got %0d want 15", write_address); else pass_count++;
      check_count++; if (write_address_gray !== 4'b1000) $display("FAIL fill_gray_hold: got %b want 1000", write_address_gray); else pass_count++;
      check_count++; if (overflow !== 1'b1) $display("FAIL fill_ovf: got %b want 1", overflow); else pass_count++;
   endtask

   task automatic test_release();
      increment = 1'b0;
      read_address_gray = 4'b0001;
      step();
      check_count++; if (full !== 1'b1) $display("FAIL release_full_e1: got %b want 1", full); else pass_count++;
      check_count++; if (level !== 4'd15) $display("FAIL release_level_e1: got %0d want 15", level); else pass_count++;
      step();
      check_count++; if (full !== 1'b0) $display("FAIL release_full_e2: got %b want 0", full); else pass_count++;
      check_count++; if (level !== 4'd14) $display("FAIL release_level_e2: got %0d want 14", level); else pass_count++;
      check_count++; if (overflow !== 1'b1) $display("FAIL release_ovf_sticky: got %b want 1", overflow); else pass_count++;
      increment = 1'b1;
      #1;
      check_count++; if (write_enable !== 1'b1) $display("FAIL release_we: got %b want 1", write_enable); else pass_count++;
      step();
      increment = 1'b0;
      check_count++; if (write_address !== 4'd0) $display("FAIL release_wa: got %0d want 0", write_address); else pass_count++;
      check_count++; if (write_address_gray !== 4'b0000) $display("FAIL release_gray: got %b want 0000", write_address_gray); else pass_count++;
      check_count++; if (full !== 1'b1) $display("FAIL release_refull: got %b want 1", full); else pass_count++;
      check_count++; if (level !== 4'd15) $display("FAIL release_level_refull: got %0d want 15", level); else pass_count++;
   endtask

   task automatic test_wrap();
      do_reset();
      increment = 1'b1;
      for (int i = 0; i < 15; i++) step();
      increment = 1'b0;
      read_address_gray = 4'b1001;
      step();
      step();
      check_count++; if (level !== 4'd1) $display("FAIL wrap_level_pre: got %0d want 1", level); else pass_count++;
      check_count++; if (full !== 1'b0) $display("FAIL wrap_full_pre: got %b want 0", full); else pass_count++;
      increment = 1'b1;
      step();
      increment = 1'b0;
      check_count++; if (write_address !== 4'd0) $display("FAIL wrap_wa: got %0d want 0", write_address); else pass_count++;
      check_count++; if (write_address_gray !== 4'b0000) $display("FAIL wrap_gray: got %b want 0000", write_address_gray); else pass_count++;
      check_count++; if (level !== 4'd2) $display("FAIL wrap_level: got %0d want 2", level); else pass_count++;
      check_count++; if (full !== 1'b0) $display("FAIL wrap_full: got %b want 0", full); else pass_count++;
   endtask

   task automatic test_almost_full();
      do_reset();
      increment = 1'b1;
      for (int i = 0; i < 11; i++) step();
      check_count++; if (level !== 4'd11) $display("FAIL af_level_11: got %0d want 11", level); else pass_count++;
      check_count++; if (almost_full !== 1'b0) $display("FAIL af_at_11: got %b want 0", almost_full); else pass_count++;
      step();
      increment = 1'b0;
      check_count++; if (level !== 4'd12) $display("FAIL af_level_12: got %0d want 12", level); else pass_count++;
      check_count++; if (almost_full !== 1'b1) $display("FAIL af_at_12: got %b want 1", almost_full); else pass_count++;
   endtask

   task automatic test_overflow_priority();
      do_reset();
      increment = 1'b1;
      for (int i = 0; i < 16; i++) step();
      check_count++; if (overflow !== 1'b1) $display("FAIL ovp_set: got %b want 1", overflow); else pass_count++;
      clear_overflow = 1'b1;
      step();
      check_count++; if (overflow !== 1'b1) $display("FAIL ovp_set_wins: got %b want 1", overflow); else pass_count++;
      check_count++; if (write_address !== 4'd15) $display("FAIL ovp_wa_hold: got %0d want 15", write_address); else pass_count++;
      increment = 1'b0;
      step();
      clear_overflow = 1'b0;
      check_count++; if (overflow !== 1'b0) $display("FAIL ovp_clear: got %b want 0", overflow); else pass_count++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_release();
      test_wrap();
      test_almost_full();
      test_overflow_priority();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
